pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Generates the PC and IF/ID enables, the IF/ID and ID/EX bubbles, and the
// fetch-handshake ready. It also discards stale fetch responses after a
// redirect, computes the EX-stage forwarding selects, and counts the cycles
// in which ID receives no new valid instruction.
module pipeline_hazard_ctrl #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [REGW-1:0] i_rs1D,
    input  logic [REGW-1:0] i_rs2D,
    input  logic [REGW-1:0] i_rs1E,
    input  logic [REGW-1:0] i_rs2E,
    input  logic [REGW-1:0] i_rdE,
    input  logic            i_memreadE,
    input  logic            i_pcsrcE,
    input  logic [REGW-1:0] i_rdM,
    input  logic            i_regwriteM,
    input  logic [REGW-1:0] i_rdW,
    input  logic            i_regwriteW,
    output logic            o_enF,
    output logic            o_enD,
    output logic            o_flushD,
    output logic            o_validD,
    output logic            o_flushE,
    output logic [1:0]      o_fwdAE,
    output logic [1:0]      o_fwdBE,
    output logic [XLEN-1:0] o_stall_cnt
);

    // RUN: outstanding fetch belongs to the current PC.
    // DROP: outstanding fetch is stale; its response is consumed and discarded.
    localparam logic RUN  = 1'b0;
    localparam logic DROP = 1'b1;

    logic            state_reg;
    logic            state_next;
    logic            valid_d_reg;
    logic            valid_d_next;
    logic [XLEN-1:0] stall_cnt_reg;
    logic [XLEN-1:0] stall_cnt_next;

    logic            lduse;
    logic            fire;
    logic            good;
    logic            in_run;

    // Load-use detection, handshake, and pipeline enable/flush generation.
    always_comb begin
        in_run     = (state_reg == RUN);
        lduse      = valid_d_reg & i_memreadE & (i_rdE != '0) &
                     ((i_rdE == i_rs1D) | (i_rdE == i_rs2D));
        o_if_ready = (in_run & ~lduse) | ~in_run;
        fire       = i_if_valid & o_if_ready;
        good       = fire & in_run & ~i_pcsrcE;
        o_enF      = i_pcsrcE | good;
        o_enD      = ~lduse;
        o_flushD   = ~lduse & ~good;
        o_flushE   = lduse | i_pcsrcE;
    end

    // Next-state logic for the fetch tracker, the ID valid bit, and the stall counter.
    always_comb begin
        state_next = state_reg;
        if (state_reg == RUN) begin
            // A redirect with no response in hand leaves a stale fetch in flight.
            if (i_pcsrcE & ~fire)
                state_next = DROP;
        end else begin
            // A new redirect while draining keeps draining; otherwise the stale
            // response retires us back to RUN.
            if (!i_pcsrcE && fire)
                state_next = RUN;
        end

        // A redirect wins over everything, including a load-use hold.
        if (i_pcsrcE)
            valid_d_next = 1'b0;
        else if (lduse)
            valid_d_next = valid_d_reg;
        else if (good)
            valid_d_next = 1'b1;
        else
            valid_d_next = 1'b0;

        if (lduse | ~good)
            stall_cnt_next = stall_cnt_reg + XLEN'(1);
        else
            stall_cnt_next = stall_cnt_reg;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg     <= RUN;
            valid_d_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            valid_d_reg   <= valid_d_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // EX-stage forwarding selects; the younger MEM result has priority over WB.
    always_comb begin
        if (i_regwriteM && (i_rdM != '0) && (i_rdM == i_rs1E))
            o_fwdAE = 2'b10;
        else if (i_regwriteW && (i_rdW != '0) && (i_rdW == i_rs1E))
            o_fwdAE = 2'b01;
        else
            o_fwdAE = 2'b00;

        if (i_regwriteM && (i_rdM != '0) && (i_rdM == i_rs2E))
            o_fwdBE = 2'b10;
        else if (i_regwriteW && (i_rdW != '0) && (i_rdW == i_rs2E))
            o_fwdBE = 2'b01;
        else
            o_fwdBE = 2'b00;
    end

    assign o_validD    = valid_d_reg;
    assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_if_valid = 1'b0;
    logic        o_if_ready;
    logic [4:0]  i_rs1D = '0, i_rs2D = '0, i_rs1E = '0, i_rs2E = '0, i_rdE = '0;
    logic        i_memreadE = 1'b0, i_pcsrcE = 1'b0;
    logic [4:0]  i_rdM = '0, i_rdW = '0;
    logic        i_regwriteM = 1'b0, i_regwriteW = 1'b0;
    logic        o_enF, o_enD, o_flushD, o_validD, o_flushE;
    logic [1:0]  o_fwdAE, o_fwdBE;
    logic [31:0] o_stall_cnt;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.XLEN(32), .REGW(5)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
        .i_rs1D(i_rs1D), .i_rs2D(i_rs2D), .i_rs1E(i_rs1E), .i_rs2E(i_rs2E),
        .i_rdE(i_rdE), .i_memreadE(i_memreadE), .i_pcsrcE(i_pcsrcE),
        .i_rdM(i_rdM), .i_regwriteM(i_regwriteM),
        .i_rdW(i_rdW), .i_regwriteW(i_regwriteW),
        .o_enF(o_enF), .o_enD(o_enD), .o_flushD(o_flushD), .o_validD(o_validD),
        .o_flushE(o_flushE), .o_fwdAE(o_fwdAE), .o_fwdBE(o_fwdBE),
        .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    // One record per cycle: inputs, then outputs expected before the clock edge.
    typedef struct packed {
        logic        if_valid;
        logic        pcsrcE;
        logic        memreadE;
        logic [4:0]  rdE;
        logic [4:0]  rs1D;
        logic [4:0]  rs2D;
        logic        if_ready;
        logic        enF;
        logic        enD;
        logic        flushD;
        logic        flushE;
        logic        validD;
        logic [31:0] cnt;
    } pipe_vec_t;

    typedef struct packed {
        logic [4:0] rdM;
        logic       wM;
        logic [4:0] rdW;
        logic       wW;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } fwd_vec_t;

    pipe_vec_t pv [17];
    fwd_vec_t  fv [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic rdy, input logic enf, input logic end_,
                             input logic fld, input logic fle);
        check({tag, ".if_ready"}, 32'(o_if_ready), 32'(rdy));
        check({tag, ".enF"},      32'(o_enF),      32'(enf));
        check({tag, ".enD"},      32'(o_enD),      32'(end_));
        check({tag, ".flushD"},   32'(o_flushD),   32'(fld));
        check({tag, ".flushE"},   32'(o_flushE),   32'(fle));
    endtask

    task automatic set_in(input logic v, input logic pc, input logic mr,
                          input logic [4:0] rde, input logic [4:0] r1, input logic [4:0] r2);
        i_if_valid = v; i_pcsrcE = pc; i_memreadE = mr;
        i_rdE = rde; i_rs1D = r1; i_rs2D = r2;
    endtask

    initial begin
        //        v  pc mr rdE rs1 rs2 | rdy enF enD fD fE vD cnt
        pv[0]  = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'd0}; // reset-exit idle
        pv[1]  = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd1}; // first fetch
        pv[2]  = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'd1}; // streaming
        pv[3]  = '{1'b1,1'b0,1'b1,5'd5,5'd1,5'd5, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'd1}; // load-use rs2
        pv[4]  = '{1'b1,1'b0,1'b0,5'd0,5'd1,5'd5, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'd2}; // resume
        pv[5]  = '{1'b1,1'b0,1'b1,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'd2}; // load rd=x0
        pv[6]  = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,32'd2}; // starve
        pv[7]  = '{1'b1,1'b1,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,32'd3}; // redirect+fire
        pv[8]  = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd4}; // still RUN
        pv[9]  = '{1'b0,1'b1,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,32'd4}; // redirect, no resp
        pv[10] = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'd5}; // DROP waiting
        pv[11] = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'd6}; // stale discarded
        pv[12] = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd7}; // back in RUN
        pv[13] = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,32'd7}; // starve
        pv[14] = '{1'b1,1'b0,1'b1,5'd5,5'd5,5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd8}; // ld match, ID empty
        pv[15] = '{1'b0,1'b0,1'b1,5'd5,5'd5,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'd8}; // load-use rs1
        pv[16] = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,32'd9}; // held then idle

        //         rdM  wM   rdW  wW   rs1E rs2E  A     B
        fv[0] = '{5'd3,1'b1,5'd3,1'b1,5'd3,5'd7,2'b10,2'b00};
        fv[1] = '{5'd3,1'b0,5'd3,1'b1,5'd3,5'd7,2'b01,2'b00};
        fv[2] = '{5'd0,1'b1,5'd3,1'b1,5'd3,5'd7,2'b01,2'b00};
        fv[3] = '{5'd0,1'b1,5'd0,1'b1,5'd0,5'd0,2'b00,2'b00};
        fv[4] = '{5'd4,1'b1,5'd7,1'b1,5'd4,5'd7,2'b10,2'b01};
        fv[5] = '{5'd7,1'b1,5'd7,1'b0,5'd2,5'd7,2'b00,2'b10};
        fv[6] = '{5'd6,1'b0,5'd6,1'b0,5'd6,5'd6,2'b00,2'b00};

        // Reset state with all inputs at 0.
        repeat (2) @(negedge i_clk);
        check_ctl("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset.validD", 32'(o_validD), 32'd0);
        check("reset.stall_cnt", o_stall_cnt, 32'd0);
        check("reset.fwdA", 32'(o_fwdAE), 32'd0);
        check("reset.fwdB", 32'(o_fwdBE), 32'd0);
        $display("txn reset: ready=%0b enF=%0b enD=%0b flushD=%0b", o_if_ready, o_enF, o_enD, o_flushD);

        // Main cycle table, first row applied at reset release.
        i_rstn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_in(pv[i].if_valid, pv[i].pcsrcE, pv[i].memreadE, pv[i].rdE, pv[i].rs1D, pv[i].rs2D);
            #1;
            $display("txn pipe[%0d]: v=%0b pc=%0b ld=%0b ready=%0b enF=%0b enD=%0b flushD=%0b flushE=%0b validD=%0b cnt=%0d",
                     i, pv[i].if_valid, pv[i].pcsrcE, pv[i].memreadE, o_if_ready, o_enF, o_enD,
                     o_flushD, o_flushE, o_validD, o_stall_cnt);
            check_ctl($sformatf("pipe[%0d]", i), pv[i].if_ready, pv[i].enF, pv[i].enD, pv[i].flushD, pv[i].flushE);
            check($sformatf("pipe[%0d].validD", i), 32'(o_validD), 32'(pv[i].validD));
            check($sformatf("pipe[%0d].stall_cnt", i), o_stall_cnt, pv[i].cnt);
            @(negedge i_clk);
        end
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Forwarding table (purely combinational).
        for (int i = 0; i < 7; i++) begin
            i_rdM = fv[i].rdM; i_regwriteM = fv[i].wM;
            i_rdW = fv[i].rdW; i_regwriteW = fv[i].wW;
            i_rs1E = fv[i].rs1E; i_rs2E = fv[i].rs2E;
            #1;
            $display("txn fwd[%0d]: rdM=%0d wM=%0b rdW=%0d wW=%0b rs1E=%0d rs2E=%0d A=%b B=%b",
                     i, fv[i].rdM, fv[i].wM, fv[i].rdW, fv[i].wW, fv[i].rs1E, fv[i].rs2E, o_fwdAE, o_fwdBE);
            check($sformatf("fwd[%0d].A", i), 32'(o_fwdAE), 32'(fv[i].fwdA));
            check($sformatf("fwd[%0d].B", i), 32'(o_fwdBE), 32'(fv[i].fwdB));
        end
        i_regwriteM = 1'b0; i_regwriteW = 1'b0;
        @(negedge i_clk);

        // Redirect while in DROP keeps DROP: the next response is still discarded.
        set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);   // RUN -> DROP
        @(negedge i_clk);
        set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);   // redirect again in DROP
        #1;
        check_ctl("drop_redir", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        $display("txn drop_redir: enF=%0b flushE=%0b", o_enF, o_flushE);
        @(negedge i_clk);
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);   // stale response
        #1;
        check_ctl("drop_stale", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("txn drop_stale: enF=%0b flushD=%0b", o_enF, o_flushD);
        @(negedge i_clk);
        #1;                                            // fresh response in RUN
        check_ctl("drop_fresh", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("drop_fresh.validD", 32'(o_validD), 32'd0);
        $display("txn drop_fresh: enF=%0b flushD=%0b", o_enF, o_flushD);
        @(negedge i_clk);
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("drop_fresh.validD_next", 32'(o_validD), 32'd1);

        // Reset asserted mid-DROP returns to RUN asynchronously.
        @(negedge i_clk);
        set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);   // enter DROP
        @(negedge i_clk);
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("pre_rst.enF", 32'(o_enF), 32'd0);       // confirms DROP
        #1 i_rstn = 1'b0;
        #1;
        check("midrst.validD", 32'(o_validD), 32'd0);
        check("midrst.stall_cnt", o_stall_cnt, 32'd0);
        check("midrst.enF", 32'(o_enF), 32'd1);        // RUN: fetch would be good
        check("midrst.flushD", 32'(o_flushD), 32'd0);
        $display("txn midrst: enF=%0b validD=%0b cnt=%0d", o_enF, o_validD, o_stall_cnt);
        @(negedge i_clk);
        i_rstn = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge i_clk);
        #1;
        check("postrst.validD", 32'(o_validD), 32'd1);
        check("postrst.stall_cnt", o_stall_cnt, 32'd0);
        $display("txn postrst: validD=%0b cnt=%0d", o_validD, o_stall_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
